// File: rtl/rgb_ycbcr_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : rgb_ycbcr_pipe
//  Description : Three-stage RGB -> YCbCr (full-range BT.601, 8 fractional
//                coefficient bits) converter with valid/ready flow control,
//                aligned sideband and a saturating clamp-event counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module rgb_ycbcr_pipe #(
    parameter int DATA_W = 8,   // channel width, legal range 8..12
    parameter int USER_W = 2,   // sideband width carried with each pixel
    parameter int CNT_W  = 16   // clamp-event counter width
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_r,
    input  logic [DATA_W-1:0] in_g,
    input  logic [DATA_W-1:0] in_b,
    input  logic [USER_W-1:0] in_user,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_y,
    output logic [DATA_W-1:0] out_cb,
    output logic [DATA_W-1:0] out_cr,
    output logic [USER_W-1:0] out_user,
    input  logic              sat_clr,
    output logic [CNT_W-1:0]  sat_cnt
);

    // Signed working width: an unsigned channel times an 8-bit coefficient,
    // summed three ways plus the chroma offset, never reaches 2^(DATA_W+10).
    localparam int SW = DATA_W + 11;

    // Coefficient set (scaled by 256)
    localparam logic signed [SW-1:0] C_YR  = SW'(77);
    localparam logic signed [SW-1:0] C_YG  = SW'(150);
    localparam logic signed [SW-1:0] C_YB  = SW'(29);
    localparam logic signed [SW-1:0] C_CBR = SW'(-43);
    localparam logic signed [SW-1:0] C_CBG = SW'(-85);
    localparam logic signed [SW-1:0] C_CBB = SW'(128);
    localparam logic signed [SW-1:0] C_CRR = SW'(128);
    localparam logic signed [SW-1:0] C_CRG = SW'(-107);
    localparam logic signed [SW-1:0] C_CRB = SW'(-21);

    // Rounding constant (half an LSB after the >>8) and chroma mid-scale offset
    localparam logic signed [SW-1:0] C_RND = SW'(128);
    localparam logic signed [SW-1:0] C_OFS = SW'(2 ** (DATA_W + 7));

    // Largest representable output code
    localparam logic signed [SW-1:0] C_MAX     = SW'(2 ** DATA_W - 1);
    localparam logic [CNT_W-1:0]     C_CNT_MAX = {CNT_W{1'b1}};

    // ------------------------------------------------------------------------
    // Flow control: the whole pipe moves as one shift register. It may move
    // whenever the output slot is empty or is being drained this cycle, so
    // bubbles travel with the data instead of being squeezed out.
    // ------------------------------------------------------------------------
    logic w_en;
    logic out_valid_q;

    assign w_en      = out_ready || !out_valid_q;
    assign in_ready  = w_en;
    assign out_valid = out_valid_q;

    // ------------------------------------------------------------------------
    // Stage 1: nine products
    // ------------------------------------------------------------------------
    logic signed [SW-1:0] w_r;
    logic signed [SW-1:0] w_g;
    logic signed [SW-1:0] w_b;
    logic signed [SW-1:0] prod_d [0:8];
    logic signed [SW-1:0] prod_q [0:8];
    logic                 valid1_q;
    logic [USER_W-1:0]    user1_q;

    // Zero-extend the channels and form every coefficient product
    always_comb begin
        w_r       = SW'(in_r);
        w_g       = SW'(in_g);
        w_b       = SW'(in_b);
        prod_d[0] = w_r * C_YR;
        prod_d[1] = w_g * C_YG;
        prod_d[2] = w_b * C_YB;
        prod_d[3] = w_r * C_CBR;
        prod_d[4] = w_g * C_CBG;
        prod_d[5] = w_b * C_CBB;
        prod_d[6] = w_r * C_CRR;
        prod_d[7] = w_g * C_CRG;
        prod_d[8] = w_b * C_CRB;
    end

    // Capture products, valid and sideband when the pipe advances
    always_ff @(posedge clk) begin
        if (rst) begin
            valid1_q <= 1'b0;
            user1_q  <= '0;
            for (int i = 0; i < 9; i++) begin
                prod_q[i] <= '0;
            end
        end else if (w_en) begin
            valid1_q <= in_valid;
            user1_q  <= in_user;
            for (int i = 0; i < 9; i++) begin
                prod_q[i] <= prod_d[i];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stage 2: three sums with offset and rounding folded in
    // ------------------------------------------------------------------------
    logic signed [SW-1:0] sum_y_d;
    logic signed [SW-1:0] sum_cb_d;
    logic signed [SW-1:0] sum_cr_d;
    logic signed [SW-1:0] sum_y_q;
    logic signed [SW-1:0] sum_cb_q;
    logic signed [SW-1:0] sum_cr_q;
    logic                 valid2_q;
    logic [USER_W-1:0]    user2_q;

    // Accumulate each output channel from its three products
    always_comb begin
        sum_y_d  = prod_q[0] + prod_q[1] + prod_q[2] + C_RND;
        sum_cb_d = prod_q[3] + prod_q[4] + prod_q[5] + C_OFS + C_RND;
        sum_cr_d = prod_q[6] + prod_q[7] + prod_q[8] + C_OFS + C_RND;
    end

    // Register the sums alongside their valid bit and sideband
    always_ff @(posedge clk) begin
        if (rst) begin
            valid2_q <= 1'b0;
            user2_q  <= '0;
            sum_y_q  <= '0;
            sum_cb_q <= '0;
            sum_cr_q <= '0;
        end else if (w_en) begin
            valid2_q <= valid1_q;
            user2_q  <= user1_q;
            sum_y_q  <= sum_y_d;
            sum_cb_q <= sum_cb_d;
            sum_cr_q <= sum_cr_d;
        end
    end

    // ------------------------------------------------------------------------
    // Stage 3: arithmetic shift, clamp to [0, 2^DATA_W-1], output registers
    // ------------------------------------------------------------------------

    // Returns {clamped_flag, clamped_value} for one accumulated sum
    function automatic logic [DATA_W:0] shift_clamp(input logic signed [SW-1:0] s);
        logic signed [SW-1:0] sh;
        sh = s >>> 8;
        if (sh[SW-1]) begin
            shift_clamp = {1'b1, {DATA_W{1'b0}}};
        end else if (sh > C_MAX) begin
            shift_clamp = {1'b1, {DATA_W{1'b1}}};
        end else begin
            shift_clamp = {1'b0, sh[DATA_W-1:0]};
        end
    endfunction

    logic [DATA_W:0]   y_d;
    logic [DATA_W:0]   cb_d;
    logic [DATA_W:0]   cr_d;
    logic              sat_any_d;
    logic [DATA_W-1:0] out_y_q;
    logic [DATA_W-1:0] out_cb_q;
    logic [DATA_W-1:0] out_cr_q;
    logic [USER_W-1:0] out_user_q;
    logic [CNT_W-1:0]  sat_cnt_q;

    // Clamp each channel and note whether any of them hit a rail
    always_comb begin
        y_d       = shift_clamp(sum_y_q);
        cb_d      = shift_clamp(sum_cb_q);
        cr_d      = shift_clamp(sum_cr_q);
        sat_any_d = y_d[DATA_W] | cb_d[DATA_W] | cr_d[DATA_W];
    end

    // Output register; holds while the sink stalls a valid pixel
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_user_q  <= '0;
            out_y_q     <= '0;
            out_cb_q    <= '0;
            out_cr_q    <= '0;
        end else if (w_en) begin
            out_valid_q <= valid2_q;
            out_user_q  <= user2_q;
            out_y_q     <= y_d[DATA_W-1:0];
            out_cb_q    <= cb_d[DATA_W-1:0];
            out_cr_q    <= cr_d[DATA_W-1:0];
        end
    end

    // Count clamped pixels as they land in the output register; the counter
    // sticks at full scale and a clear overrides a coincident increment
    always_ff @(posedge clk) begin
        if (rst) begin
            sat_cnt_q <= '0;
        end else if (sat_clr) begin
            sat_cnt_q <= '0;
        end else if (w_en && valid2_q && sat_any_d && (sat_cnt_q != C_CNT_MAX)) begin
            sat_cnt_q <= sat_cnt_q + 1'b1;
        end
    end

    assign out_y    = out_y_q;
    assign out_cb   = out_cb_q;
    assign out_cr   = out_cr_q;
    assign out_user = out_user_q;
    assign sat_cnt  = sat_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_rgb_ycbcr_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rgb_ycbcr_pipe
//  Description : Scoreboard bench for rgb_ycbcr_pipe. Accepted pixels are
//                converted by an integer reference model and queued; a monitor
//                pops and compares each pixel the DUT presents.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rgb_ycbcr_pipe;

    localparam int CNT_MAX = 15;   // main instance uses a 4-bit counter

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_ready, out_valid, out_ready, sat_clr;
    logic [7:0] in_r, in_g, in_b, out_y, out_cb, out_cr;
    logic [1:0] in_user, out_user;
    logic [3:0] sat_cnt;

    logic        v10, rdy10, ov10, sclr10;
    logic [9:0]  r10, g10, b10, y10, cb10, cr10;
    logic [1:0]  u10, ou10;
    logic [15:0] sc10;

    always #5 clk = ~clk;

    rgb_ycbcr_pipe #(.DATA_W(8), .USER_W(2), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_r(in_r), .in_g(in_g), .in_b(in_b), .in_user(in_user),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_y(out_y), .out_cb(out_cb), .out_cr(out_cr), .out_user(out_user),
        .sat_clr(sat_clr), .sat_cnt(sat_cnt)
    );

    rgb_ycbcr_pipe #(.DATA_W(10), .USER_W(2), .CNT_W(16)) dut10 (
        .clk(clk), .rst(rst), .in_valid(v10), .in_ready(rdy10),
        .in_r(r10), .in_g(g10), .in_b(b10), .in_user(u10),
        .out_valid(ov10), .out_ready(1'b1),
        .out_y(y10), .out_cb(cb10), .out_cr(cr10), .out_user(ou10),
        .sat_clr(sclr10), .sat_cnt(sc10)
    );

    typedef struct {
        int y; int cb; int cr; int user; bit sat; int cyc; bit lat;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_mis = 0;
    int   cyc = 0;
    bit   lat_mode = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp_v);
        n_vec++;
        if (act != exp_v) begin
            n_mis++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp_v, $time);
        end
    endtask

    // Reference conversion straight from the BT.601 integer formulas
    function automatic void ref_px(input int dw, input int r, input int g, input int b,
                                   output int y, output int cb, output int cr, output bit sat);
        int ofs; int mx; int t[3];
        ofs  = 1 << (dw + 7);
        mx   = (1 << dw) - 1;
        t[0] = (77 * r + 150 * g + 29 * b + 128) >>> 8;
        t[1] = (-43 * r - 85 * g + 128 * b + ofs + 128) >>> 8;
        t[2] = (128 * r - 107 * g - 21 * b + ofs + 128) >>> 8;
        sat  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (t[i] < 0) begin t[i] = 0; sat = 1'b1; end
            else if (t[i] > mx) begin t[i] = mx; sat = 1'b1; end
        end
        y = t[0]; cb = t[1]; cr = t[2];
    endfunction

    // Stimulus side of the scoreboard: every accepted pixel queues its result
    always @(negedge clk) begin : accept_p
        exp_t e;
        if (!rst && in_valid && in_ready) begin
            ref_px(8, int'(in_r), int'(in_g), int'(in_b), e.y, e.cb, e.cr, e.sat);
            e.user = int'(in_user);
            e.cyc  = cyc;
            e.lat  = lat_mode;
            sb.push_back(e);
        end
    end

    // Monitor: pops on each newly presented pixel, checks stall stability
    // and tracks the expected clamp counter
    bit   prev_stall = 1'b0;
    bit   clr_pend = 1'b0;
    int   sat_exp = 0;
    int   py, pcb, pcr, pu;
    always @(negedge clk) begin : monitor_p
        exp_t cur;
        bit   new_item;
        bit   cur_sat;
        if (rst) begin
            sb.delete();
            sat_exp    = 0;
            clr_pend   = 1'b0;
            prev_stall = 1'b0;
        end else begin
            new_item = 1'b0;
            cur_sat  = 1'b0;
            if (prev_stall) begin
                chk("hold_valid", int'(out_valid), 1);
                chk("hold_y", int'(out_y), py);
                chk("hold_cb", int'(out_cb), pcb);
                chk("hold_cr", int'(out_cr), pcr);
                chk("hold_user", int'(out_user), pu);
            end else if (out_valid) begin
                new_item = 1'b1;
            end
            if (new_item) begin
                if (sb.size() == 0) begin
                    chk("unexpected_out_valid", int'(out_valid), 0);
                end else begin
                    cur = sb.pop_front();
                    chk("y", int'(out_y), cur.y);
                    chk("cb", int'(out_cb), cur.cb);
                    chk("cr", int'(out_cr), cur.cr);
                    chk("user", int'(out_user), cur.user);
                    if (cur.lat) chk("latency", cyc - cur.cyc, 3);
                    cur_sat = cur.sat;
                end
            end
            if (clr_pend) sat_exp = 0;
            else if (new_item && cur_sat && sat_exp < CNT_MAX) sat_exp++;
            chk("sat_cnt", int'(sat_cnt), sat_exp);
            clr_pend   = sat_clr;
            prev_stall = out_valid && !out_ready;
            py  = int'(out_y);
            pcb = int'(out_cb);
            pcr = int'(out_cr);
            pu  = int'(out_user);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int r, input int g, input int b, input int u);
        bit ok = 1'b0;
        int n  = 0;
        in_valid = 1'b1;
        in_r = 8'(r); in_g = 8'(g); in_b = 8'(b); in_user = 2'(u);
        while (!ok && n < 100) begin
            @(negedge clk);
            ok = in_ready;
            n++;
            step();
        end
        if (!ok) chk("send_timeout", int'(ok), 1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        bit done = 1'b0;
        out_ready = 1'b1;
        for (int n = 0; n < 300 && !done; n++) begin
            @(negedge clk);
            done = (sb.size() == 0) && !out_valid;
        end
        if (!done) chk("drain_timeout", int'(done), 1);
        step();
    endtask

    task automatic rand_px(input int u);
        in_r = 8'($urandom); in_g = 8'($urandom); in_b = 8'($urandom);
        in_user = 2'(u);
    endtask

    int s10_exp = 0;
    task automatic send10(input int r, input int g, input int b, input int u);
        int ey, ecb, ecr; bit es; bit got = 1'b0;
        ref_px(10, r, g, b, ey, ecb, ecr, es);
        if (es) s10_exp++;
        v10 = 1'b1; r10 = 10'(r); g10 = 10'(g); b10 = 10'(b); u10 = 2'(u);
        step();
        v10 = 1'b0;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            got = ov10;
        end
        chk("d10_out_valid", int'(got), 1);
        chk("d10_y", int'(y10), ey);
        chk("d10_cb", int'(cb10), ecb);
        chk("d10_cr", int'(cr10), ecr);
        chk("d10_user", int'(ou10), u);
        chk("d10_sat_cnt", int'(sc10), s10_exp);
        step();
    endtask

    initial begin : driver
        int i; int k; bit fresh;
        rst = 1'b1; in_valid = 1'b0; in_r = '0; in_g = '0; in_b = '0; in_user = '0;
        out_ready = 1'b1; sat_clr = 1'b0;
        v10 = 1'b0; r10 = '0; g10 = '0; b10 = '0; u10 = '0; sclr10 = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_y", int'(out_y), 0);
        chk("rst_out_cb", int'(out_cb), 0);
        chk("rst_out_cr", int'(out_cr), 0);
        chk("rst_out_user", int'(out_user), 0);
        chk("rst_sat_cnt", int'(sat_cnt), 0);
        chk("rst_d10_out_valid", int'(ov10), 0);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("in_ready_after_rst", int'(in_ready), 1);
        step();

        // Black then white, back to back, with latency checked; then red/blue
        lat_mode = 1'b1;
        send(0, 0, 0, 0);
        send(255, 255, 255, 1);
        drain();
        chk("sat_after_bw", int'(sat_cnt), 0);
        send(255, 0, 0, 2);
        send(0, 0, 255, 3);
        drain();
        chk("sat_after_red_blue", int'(sat_cnt), 2);
        repeat (8) send(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                        int'($urandom_range(0, 255)), int'($urandom_range(0, 3)));
        drain();
        lat_mode = 1'b0;

        // 16 pixels with out_ready cycling 1,0,0
        i = 0; k = 0; fresh = 1'b1;
        while ((i < 16 || sb.size() != 0) && k < 400) begin
            out_ready = (k % 3 == 0);
            if (i < 16) begin
                if (fresh) rand_px(i);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            fresh = in_valid && in_ready;
            if (fresh) i++;
            step();
            k++;
        end
        in_valid = 1'b0;
        chk("stall_stream_accepted", i, 16);
        drain();

        // Random valid/ready traffic
        fresh = 1'b1;
        for (int n = 0; n < 400; n++) begin
            if (fresh) rand_px(int'($urandom_range(0, 3)));
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            @(negedge clk);
            fresh = !in_valid || in_ready;
            step();
        end
        in_valid = 1'b0;
        drain();

        // Counter saturation, hold, and clear racing an increment
        repeat (20) send(255, 0, 0, 0);
        drain();
        chk("sat_at_max", int'(sat_cnt), CNT_MAX);
        repeat (3) send(0, 0, 255, 1);
        drain();
        chk("sat_holds_max", int'(sat_cnt), CNT_MAX);
        in_valid = 1'b1; in_r = 8'd255; in_g = 8'd0; in_b = 8'd0; in_user = 2'd2;
        step();                 // red accepted on this edge
        in_valid = 1'b0;
        step();                 // red now in the sum stage
        sat_clr = 1'b1;
        step();                 // red enters output register as clear takes effect
        sat_clr = 1'b0;
        @(negedge clk);
        chk("sat_clr_wins", int'(sat_cnt), 0);
        drain();
        chk("sat_after_clr", int'(sat_cnt), 0);

        // Reset with three pixels in flight
        out_ready = 1'b1;
        repeat (3) begin
            rand_px(3);
            in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_in_ready", int'(in_ready), 1);
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_out_y", int'(out_y), 0);
        chk("midrst_out_cb", int'(out_cb), 0);
        chk("midrst_out_cr", int'(out_cr), 0);
        chk("midrst_out_user", int'(out_user), 0);
        chk("midrst_sat_cnt", int'(sat_cnt), 0);
        repeat (5) begin
            @(negedge clk);
            chk("midrst_no_output", int'(out_valid), 0);
        end
        step();
        send(0, 0, 255, 1);
        drain();

        // Ten-bit instance
        chk("d10_in_ready", int'(rdy10), 1);
        send10(1023, 1023, 1023, 1);
        chk("d10_white_no_clamp", int'(sc10), 0);
        send10(0, 0, 0, 2);
        send10(1023, 0, 0, 3);
        repeat (3) send10(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)),
                          int'($urandom_range(0, 1023)), int'($urandom_range(0, 3)));

        repeat (3) step();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
